frame_capture_ctrl: RTL and testbench
=====================================

// Module: frame_capture_ctrl
// PURPOSE
// - Sequences the camera byte stream into the frame-buffer BRAM write port: arms on start, syncs to frame start
//   (vsync fall), generates wr_addr/wr_data/wr_en per pixel, counts lines/columns and reports frame completion.
// - Sits between the SCCB config unit (config_done) and the frame-buffer port A; replaces free-running capture.
// PARAMETERS
// - H_ACTIVE   640  pixels per line stored; extra pixels in a line are dropped
// - V_ACTIVE   480  lines per frame stored; extra lines are dropped
// - BPP        2    camera bytes per pixel; byte 0 of each pixel carries the luma/high byte
// - ADDR_W     19   write-address width; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE
// - DATA_W     4    stored pixel width = upper DATA_W bits of byte 0
// PORTS
// - clk          in   1       system clock; all logic on rising edge
// - reset_n      in   1       asynchronous, active-low reset
// - cam_byte_en  in   1       one-cycle strobe per camera byte (pre-synchronised to clk)
// - cam_href     in   1       line-valid, sampled only when cam_byte_en=1
// - cam_vsync    in   1       frame sync, sampled every cycle
// - cam_data     in   8       camera byte, valid with cam_byte_en
// - config_done  in   1       sensor configured; capture cannot arm while 0
// - start        in   1       one-cycle arm request
// - continuous   in   1       1: re-arm after each frame; 0: single shot; sampled on start
// - wr_en        out  1       BRAM write enable
// - wr_addr      out  ADDR_W  BRAM write address
// - wr_data      out  DATA_W  BRAM write data
// - busy         out  1       high in WAIT_SOF and CAPTURE
// - frame_done   out  1       one-cycle pulse at end of a captured frame
// - short_err    out  1       sticky: a line ended with fewer than H_ACTIVE pixels; cleared by start
// - frame_cnt    out  16      completed frames, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; counters 0; continuous latch 0.
// - Input stage: cam_vsync/cam_href/cam_data/cam_byte_en registered once; vsync edge = registered vs. prior value.
// - FSM: IDLE -> WAIT_SOF on start && config_done (start ignored otherwise, and ignored when not IDLE).
//   WAIT_SOF -> CAPTURE on vsync falling edge; x=0, y=0, byte_idx=0, addr=0.
//   CAPTURE -> DONE on vsync rising edge, or when y reaches V_ACTIVE.
//   DONE (1 cycle): frame_done=1, frame_cnt+1; -> WAIT_SOF if continuous latch else IDLE.
// - config_done falling in any state -> IDLE next cycle, no frame_done, no further writes.
// - In CAPTURE, per registered byte strobe with href=1: byte_idx counts 0..BPP-1 and wraps; at byte_idx=0 and
//   x<H_ACTIVE: wr_en=1, wr_data=data[7:8-DATA_W], wr_addr=y*H_ACTIVE+x (running counter, no multiplier); x+1.
// - Latency: wr_* registered; valid 2 clk after the cam_byte_en cycle; wr_en is a 1-cycle pulse.
// - href falling edge (line end): if x<H_ACTIVE set short_err; address jumps to (y+1)*H_ACTIVE; y+1; x=0, byte_idx=0.
// - Pixels with x>=H_ACTIVE and lines with y>=V_ACTIVE never write; wr_addr never exceeds H_ACTIVE*V_ACTIVE-1.
// - vsync rise and href fall in same cycle: line end processed first, then DONE.
// - Bytes while href=0, or outside CAPTURE, are ignored.
// CONFIGURATION
// - FCAP_TEST_PATTERN_EN defined: wr_data = (x ^ y)[DATA_W-1:0] instead of camera data; timing/addresses unchanged.
// - Undefined: wr_data from cam_data as above; no pattern logic synthesised.
// STRUCTURE
// - Package fcap_pkg: state enum fcap_state_t {IDLE, WAIT_SOF, CAPTURE, DONE}; default geometry constants
//   (H_ACTIVE_DEF=640, V_ACTIVE_DEF=480, BPP_DEF=2).
// - One sub-module: fcap_sync_edge (input register + rise/fall detect for vsync and href).
// TESTING (bench: H_ACTIVE=8, V_ACTIVE=4, BPP=2, DATA_W=4)
// - Reset mid-CAPTURE (reset_n low 1 cycle) -> all outputs 0, state IDLE, next start required.
// - start with config_done=0 -> stays IDLE, busy=0; raise config_done, start -> busy=1 next cycle.
// - Full frame 4 lines x 8 px, byte0=0xA0+x -> 32 writes, addr 0..31, data 0xA, frame_done once, frame_cnt=1.
// - Line of 5 px -> short_err=1; next line's first write at addr 8*(y+1), not 5.
// - Line of 10 px and 6 lines -> exactly 32 writes, max addr 31; DONE entered at y=4 before vsync rise.
// - continuous=1, three frames -> frame_cnt=3, busy stays 1; drop config_done mid-frame -> IDLE, no frame_done.

Source files
------------

// File: rtl/fcap_pkg.sv
// Shared types and default geometry for the frame capture controller.
package fcap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } fcap_state_t;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned BPP_DEF      = 2;
    localparam int unsigned ADDR_W_DEF   = 19;
    localparam int unsigned DATA_W_DEF   = 4;

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Camera byte stream in, frame-buffer write port out.
interface frame_capture_ctrl_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DATA_W = 4
);
    logic              cam_byte_en;
    logic              cam_href;
    logic              cam_vsync;
    logic [7:0]        cam_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output cam_byte_en, cam_href, cam_vsync, cam_data,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cam_byte_en, cam_href, cam_vsync, cam_data,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fcap_sync_edge.sv
// Registers the camera inputs once and detects vsync edges and the href falling edge.
module fcap_sync_edge (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cam_byte_en,
    input  logic       cam_href,
    input  logic       cam_vsync,
    input  logic [7:0] cam_data,
    output logic       byte_en,
    output logic       href,
    output logic [7:0] data,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic       href_fall
);
    logic vsync_q;
    logic vsync_prev;
    logic href_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_en    <= 1'b0;
            href       <= 1'b0;
            data       <= 8'h00;
            vsync_q    <= 1'b0;
            vsync_prev <= 1'b0;
            href_prev  <= 1'b0;
        end else begin
            byte_en    <= cam_byte_en;
            data       <= cam_data;
            vsync_q    <= cam_vsync;
            vsync_prev <= vsync_q;
            // href is only meaningful alongside a byte strobe
            if (cam_byte_en) href <= cam_href;
            href_prev  <= href;
        end
    end

    assign vsync_rise = vsync_q & ~vsync_prev;
    assign vsync_fall = ~vsync_q & vsync_prev;
    assign href_fall  = ~href & href_prev;
endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: camera bytes -> frame-buffer writes, one pixel per BPP bytes.
// Define FCAP_TEST_PATTERN_EN to store (x ^ y) instead of camera data.
module frame_capture_ctrl
    import fcap_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned BPP      = BPP_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    frame_capture_ctrl_if.slave bus,
    input  logic                config_done,
    input  logic                start,
    input  logic                continuous,
    output logic                busy,
    output logic                frame_done,
    output logic                short_err,
    output logic [15:0]         frame_cnt
);
    localparam int unsigned XW = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW = $clog2(V_ACTIVE + 1);
    localparam int unsigned BW = (BPP > 1) ? $clog2(BPP) : 1;

    logic              s_byte_en, s_href, vsync_rise, vsync_fall, href_fall;
    logic [7:0]        s_data;
    logic [DATA_W-1:0] pix_data;
    logic              unused_data;

    fcap_state_t       state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [ADDR_W-1:0] addr_q, addr_d, line_base_q, line_base_d;
    logic              cont_q, cont_d, short_err_q, short_err_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    fcap_sync_edge u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .cam_byte_en(bus.cam_byte_en),
        .cam_href   (bus.cam_href),
        .cam_vsync  (bus.cam_vsync),
        .cam_data   (bus.cam_data),
        .byte_en    (s_byte_en),
        .href       (s_href),
        .data       (s_data),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .href_fall  (href_fall)
    );

`ifdef FCAP_TEST_PATTERN_EN
    assign pix_data = DATA_W'(x_q) ^ DATA_W'(y_q);
`else
    assign pix_data = s_data[7 -: DATA_W];
`endif
    assign unused_data = ^s_data;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        bidx_d      = bidx_q;
        addr_d      = addr_q;
        line_base_d = line_base_q;
        cont_d      = cont_q;
        short_err_d = short_err_q;
        frame_cnt_d = frame_cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start && config_done) begin
                    state_d     = WAIT_SOF;
                    cont_d      = continuous;
                    short_err_d = 1'b0;
                end
            end
            WAIT_SOF: begin
                if (vsync_fall) begin
                    state_d     = CAPTURE;
                    x_d         = '0;
                    y_d         = '0;
                    bidx_d      = '0;
                    addr_d      = '0;
                    line_base_d = '0;
                end
            end
            CAPTURE: begin
                if (s_byte_en && s_href) begin
                    if (bidx_q == '0 && x_q < XW'(H_ACTIVE)) begin
                        x_d = x_q + 1'b1;
                        if (y_q < YW'(V_ACTIVE)) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = pix_data;
                            addr_d    = addr_q + 1'b1;
                        end
                    end
                    bidx_d = (bidx_q == BW'(BPP - 1)) ? '0 : bidx_q + 1'b1;
                end
                // Line end jumps to the next row base, so short lines leave a gap
                if (href_fall) begin
                    if (x_q < XW'(H_ACTIVE)) short_err_d = 1'b1;
                    line_base_d = line_base_q + ADDR_W'(H_ACTIVE);
                    addr_d      = line_base_d;
                    y_d         = y_q + 1'b1;
                    x_d         = '0;
                    bidx_d      = '0;
                end
                if (vsync_rise || y_d == YW'(V_ACTIVE)) state_d = DONE;
            end
            DONE: begin
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = cont_q ? WAIT_SOF : IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Losing sensor configuration aborts everything without a completion pulse
        if (state_q != IDLE && !config_done) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            bidx_q      <= '0;
            addr_q      <= '0;
            line_base_q <= '0;
            cont_q      <= 1'b0;
            short_err_q <= 1'b0;
            frame_cnt_q <= 16'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bidx_q      <= bidx_d;
            addr_q      <= addr_d;
            line_base_q <= line_base_d;
            cont_q      <= cont_d;
            short_err_q <= short_err_d;
            frame_cnt_q <= frame_cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q == WAIT_SOF) || (state_q == CAPTURE);
    assign frame_done  = (state_q == DONE);
    assign short_err   = short_err_q;
    assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl with a small 8x4 geometry.
module tb_frame_capture_ctrl;
    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 4;
`ifdef FCAP_TEST_PATTERN_EN
    localparam bit TP = 1'b1;
`else
    localparam bit TP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        config_done, start, continuous;
    logic        busy, frame_done, short_err;
    logic [15:0] frame_cnt;

    frame_capture_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    frame_capture_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .BPP(2), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .config_done(config_done),
        .start      (start),
        .continuous (continuous),
        .busy       (busy),
        .frame_done (frame_done),
        .short_err  (short_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  fd_cnt   = 0;
    int  wr_cnt   = 0;
    int  max_addr = 0;

    // Monitor: every write must match the head of the expectation queue
    always @(negedge clk) begin : mon
        wr_t e;
        if (reset_n) begin
            if (frame_done) fd_cnt++;
            if (bus.wr_en) begin
                wr_cnt++;
                if (int'(bus.wr_addr) > max_addr) max_addr = int'(bus.wr_addr);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                             bus.wr_addr, bus.wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.addr !== bus.wr_addr || e.data !== bus.wr_data) begin
                        n_fail++;
                        $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                                 bus.wr_addr, bus.wr_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [7:0] b0, input int x, input int y);
        logic [DW-1:0] pat;
        pat = DW'(x ^ y);
        return TP ? pat : b0[7:4];
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic h);
        bus.cam_data    = d;
        bus.cam_href    = h;
        bus.cam_byte_en = 1'b1;
        tick();
        bus.cam_byte_en = 1'b0;
        tick();
    endtask

    task automatic send_px(input int y, input int x, input logic [7:0] base, input bit expect_wr);
        logic [7:0] b0;
        wr_t        w;
        b0 = base + 8'(x);
        if (expect_wr && x < int'(H) && y < int'(V)) begin
            w.addr = AW'(y * int'(H) + x);
            w.data = exp_data(b0, x, y);
            exp_q.push_back(w);
        end
        send_byte(b0, 1'b1);
        send_byte(8'h0F, 1'b1);
    endtask

    task automatic line_end();
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
    endtask

    task automatic send_line(input int y, input int npix, input logic [7:0] base,
                             input bit expect_wr);
        for (int x = 0; x < npix; x++) send_px(y, x, base, expect_wr);
        line_end();
    endtask

    task automatic vsync_start();
        bus.cam_vsync = 1'b1;
        tick();
        tick();
        bus.cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic vsync_end();
        bus.cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_start(input logic c);
        continuous = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    int fd0;
    int wr0;

    initial begin
        bus.cam_byte_en = 1'b0;
        bus.cam_href    = 1'b0;
        bus.cam_vsync   = 1'b1;
        bus.cam_data    = 8'h00;
        config_done     = 1'b0;
        start           = 1'b0;
        continuous      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);

        // Arming refused without sensor configuration
        pulse_start(1'b0);
        tick();
        check("start_no_cfg_busy", 32'(busy), 0);
        config_done = 1'b1;
        tick();
        pulse_start(1'b0);
        check("start_cfg_busy", 32'(busy), 1);

        // Full 8x4 frame
        vsync_start();
        for (int y = 0; y < 4; y++) send_line(y, 8, 8'hA0, 1'b1);
        vsync_end();
        check("f1_frame_done", 32'(fd_cnt), 1);
        check("f1_frame_cnt", 32'(frame_cnt), 1);
        check("f1_busy", 32'(busy), 0);
        check("f1_short_err", 32'(short_err), 0);
        check("f1_writes", 32'(wr_cnt), 32);
        check("f1_max_addr", 32'(max_addr), 31);
        check("f1_queue", 32'(exp_q.size()), 0);

        // Short second line
        pulse_start(1'b0);
        vsync_start();
        send_line(0, 8, 8'h50, 1'b1);
        send_line(1, 5, 8'h50, 1'b1);
        send_line(2, 8, 8'h50, 1'b1);
        send_line(3, 8, 8'h50, 1'b1);
        vsync_end();
        check("f2_short_err", 32'(short_err), 1);
        check("f2_frame_cnt", 32'(frame_cnt), 2);
        check("f2_queue", 32'(exp_q.size()), 0);

        // Overlong lines and extra lines
        pulse_start(1'b0);
        check("f3_short_clear", 32'(short_err), 0);
        wr0      = wr_cnt;
        max_addr = 0;
        vsync_start();
        for (int y = 0; y < 4; y++) send_line(y, 10, 8'hC0, 1'b1);
        check("f3_done_before_vsync", 32'(fd_cnt), 3);
        check("f3_busy_after_done", 32'(busy), 0);
        for (int y = 4; y < 6; y++) send_line(y, 10, 8'hC0, 1'b0);
        vsync_end();
        check("f3_writes", 32'(wr_cnt - wr0), 32);
        check("f3_max_addr", 32'(max_addr), 31);
        check("f3_frame_done", 32'(fd_cnt), 3);
        check("f3_frame_cnt", 32'(frame_cnt), 3);
        check("f3_short_err", 32'(short_err), 0);

        // Reset in the middle of a capture
        pulse_start(1'b0);
        vsync_start();
        send_line(0, 3, 8'h30, 1'b1);
        for (int x = 0; x < 4; x++) send_px(1, x, 8'h30, 1'b1);
        tick();
        tick();
        check("mid_short_err", 32'(short_err), 1);
        check("mid_busy", 32'(busy), 1);
        check("mid_queue", 32'(exp_q.size()), 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_wr_en", 32'(bus.wr_en), 0);
        check("mid_rst_wr_addr", 32'(bus.wr_addr), 0);
        check("mid_rst_wr_data", 32'(bus.wr_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_frame_done", 32'(frame_done), 0);
        check("mid_rst_short_err", 32'(short_err), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        vsync_end();
        vsync_start();
        send_line(0, 8, 8'h30, 1'b0);
        check("mid_no_rearm_busy", 32'(busy), 0);

        // Continuous mode, three frames
        fd0 = fd_cnt;
        pulse_start(1'b1);
        for (int f = 0; f < 3; f++) begin
            vsync_start();
            for (int y = 0; y < 4; y++) send_line(y, 8, 8'h60 + 8'(f * 16), 1'b1);
            vsync_end();
            check("cont_busy", 32'(busy), 1);
        end
        check("cont_frame_cnt", 32'(frame_cnt), 3);
        check("cont_frame_done", 32'(fd_cnt - fd0), 3);

        // Configuration lost mid-frame
        vsync_start();
        send_line(0, 8, 8'h90, 1'b1);
        for (int x = 0; x < 3; x++) send_px(1, x, 8'h90, 1'b1);
        tick();
        tick();
        config_done = 1'b0;
        tick();
        tick();
        check("drop_busy", 32'(busy), 0);
        for (int x = 3; x < 8; x++) send_px(1, x, 8'h90, 1'b0);
        line_end();
        vsync_end();
        check("drop_no_frame_done", 32'(fd_cnt - fd0), 3);
        check("drop_frame_cnt", 32'(frame_cnt), 3);
        check("final_queue", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
